mc_control_fsm: RTL
===================

# mc_control_fsm

Multicycle control unit for the 8-bit CPU. It decodes the instruction register and drives, once per cycle, every datapath select and write enable: address, operand-A register, register-input, ALU input 1 and ALU input 2 muxes, plus PC, IR, MDR, register-file and memory strobes. It sits beside the datapath and exchanges a simple request/ready handshake with instruction/data memory.

## Interface
Parameters:
- none; state encoding and opcodes are fixed by this spec.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH.
- ir  in  8  instruction register contents; valid from DECODE onward.
- zero  in  1  registered ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req.
- addrsel  out  1  0 = address from PC, 1 = address from OpB.
- opa_sel  out  1  0 = OpA register from ir[7:6], 1 = forced register r1.
- reg_in  out  1  register write data: 0 = ALUout, 1 = MDR.
- alu1  out  1  ALU input 1: 0 = PC, 1 = OpA.
- alu2  out  3  ALU input 2: 000 OpB, 001 constant 1, 010 Imm4, 011 Imm5, 100 Imm3.
- alu_op  out  2  00 ADD, 01 SUB, 10 NAND, 11 OR.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = live ALU result, 1 = ALUout register.
- ir_write  out  1  load IR from memory data.
- mdr_write  out  1  load MDR from memory data.
- reg_write  out  1  register-file write; destination is the selected OpA register.
- halted  out  1  high in HALT.
- state  out  4  current state code, for debug.

## Operation
- Opcode decode, in priority order:
  - ir[3:0]: 0100 ADD, 0110 SUB, 1000 NAND, 0000 LOAD, 0010 STORE, 0101 BZ, 1001 BNZ.
  - Otherwise ir[2:0]: 011 ADDI (Imm3 = ir[5:3]), 111 ORI (Imm5 = ir[7:3], always targets r1).
  - Anything else is illegal.
- Register fields: rA = ir[7:6], rB = ir[5:4]. Imm4 = ir[7:4]. Sign extension is done in the datapath.
- Outputs are Moore decodes of state, except the strobes gated by mem_ready or zero as noted below. Every output not listed for a state is 0.
- FETCH (0): mem_req=1, addrsel=0, alu1=0, alu2=001, alu_op=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1): alu1=0, alu2=010, alu_op=ADD, so ALUout latches PC+Imm4 as the branch target. Next state by opcode:
  - R-type → EXEC_R
  - ADDI → EXEC_I
  - ORI → EXEC_ORI
  - LOAD → MEM_RD
  - STORE → MEM_WR
  - BZ/BNZ → BRANCH
  - illegal → HALT
- EXEC_R (2): alu1=1, alu2=000, alu_op per opcode; → WB_ALU.
- EXEC_I (3): alu1=1, alu2=100, ADD; → WB_ALU.
- EXEC_ORI (4): opa_sel=1, alu1=1, alu2=011, OR; → WB_ALU.
- WB_ALU (5): reg_write=1, reg_in=0; opa_sel held at 1 if the opcode is ORI; → FETCH.
- MEM_RD (6): mem_req=1, mem_we=0, addrsel=1.
  - When mem_ready=1: mdr_write=1; go to WB_MEM.
  - Otherwise stay in MEM_RD.
- WB_MEM (7): reg_write=1, reg_in=1; → FETCH.
- MEM_WR (8): mem_req=1, mem_we=1, addrsel=1.
  - When mem_ready=1: go to FETCH.
  - Otherwise stay in MEM_WR.
- BRANCH (9): pc_src=1.
  - pc_write = zero for BZ, ~zero for BNZ.
  - → FETCH.
- HALT (15): halted=1; stays in HALT until reset.
- Unused state codes 10–14 → FETCH on the next edge.

## Timing
- Reset: state=FETCH immediately (asynchronous). All strobes are 0 except the FETCH decodes: mem_req=1, alu2=001. halted=0.
- First fetch request is visible in the cycle after reset deasserts.
- Cycles per instruction with zero-wait memory:
  - R-type, ADDI, ORI: 4
  - LOAD: 4
  - STORE: 3
  - branch: 3
- Each wait cycle (mem_ready=0) adds one cycle in FETCH, MEM_RD or MEM_WR.
- Handshake rules:
  - mem_req, mem_we and addrsel hold stable throughout a wait.
  - ir_write, pc_write (in FETCH) and mdr_write pulse exactly once, in the mem_ready cycle.
  - mem_ready outside a memory state is ignored.
- ir must be stable from DECODE until the instruction returns to FETCH; the FSM never re-reads memory mid-instruction.
- Reset asserted mid-wait or mid-instruction: the access is abandoned, no write strobes fire, and execution restarts in FETCH.

## Test plan
- Reset then ir=0x54 (ADD r1,r1) with mem_ready=1 → states 0,1,2,5,0. alu_op=00 in EXEC_R. reg_write=1 only in WB_ALU, with reg_in=0.
- LOAD ir=0x20 with mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with addrsel=1, mem_we=0. Single mdr_write pulse. WB_MEM has reg_in=1.
- STORE ir=0x62 with mem_ready=1 → MEM_WR for 1 cycle with mem_req=1, mem_we=1, addrsel=1. No reg_write anywhere in the instruction.
- BZ ir=0x35 with zero=1, then again with zero=0 → BRANCH pc_write=1, pc_src=1 in the first case; pc_write=0 in the second. DECODE drives alu2=010 in both.
- ORI ir=0xAF → EXEC_ORI drives opa_sel=1, alu2=011, alu_op=11; WB_ALU drives reg_write=1 with opa_sel=1.
- Illegal ir=0x0C → HALT with halted=1 held for 10 cycles. Asserting reset asynchronously mid-cycle → state=0 before the next clock edge.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: bundle between the multicycle control FSM and the
// 8-bit CPU datapath / memory.
//
// Signals
//   ir, zero        datapath -> control: instruction register, registered ALU zero flag
//   mem_ready       memory   -> control: current access completes this cycle
//   mem_req/mem_we  control  -> memory : access request, 1 = write
//   addrsel..alu_op control  -> datapath mux selects and ALU operation
//   pc_write..reg_write control -> datapath write strobes
//   halted, state   control  -> observers: halt flag and current state code
//
// Handshake: mem_req (with mem_we and addrsel) is a request that stays
// asserted and stable until a cycle in which mem_ready is high; the access
// completes in exactly that cycle, and the load strobes tied to it
// (ir_write, pc_write in FETCH, mdr_write) pulse only in that cycle.
// mem_ready seen while no request is pending has no effect.
//
// Modports: master = control unit, slave = datapath/memory side.
interface mc_control_fsm_if;
  logic [7:0] ir;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addrsel;
  logic       opa_sel;
  logic       reg_in;
  logic       alu1;
  logic [2:0] alu2;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       pc_src;
  logic       ir_write;
  logic       mdr_write;
  logic       reg_write;
  logic       halted;
  logic [3:0] state;

  modport master (
    input  ir, zero, mem_ready,
    output mem_req, mem_we, addrsel, opa_sel, reg_in, alu1, alu2, alu_op,
           pc_write, pc_src, ir_write, mdr_write, reg_write, halted, state
  );

  modport slave (
    output ir, zero, mem_ready,
    input  mem_req, mem_we, addrsel, opa_sel, reg_in, alu1, alu2, alu_op,
           pc_write, pc_src, ir_write, mdr_write, reg_write, halted, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control unit for the 8-bit CPU.
// Decodes the instruction register and drives every datapath select and
// write enable once per cycle, and runs the request/ready handshake with
// instruction/data memory.
//
// Ports
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high; forces FETCH
//   bus    mc_control_fsm_if.master (see interface header for signal list)
//
// Moore outputs are registered: they are computed from the next state and
// loaded on the same edge as the state register, so they are glitch-free and
// line up with the state code. The strobes that depend on mem_ready or zero
// in the current cycle (ir_write, pc_write, mdr_write) are decoded
// combinationally from the current state.
module mc_control_fsm (
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_ORI = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_NAND, OP_LOAD, OP_STORE,
    OP_BZ, OP_BNZ, OP_ADDI, OP_ORI, OP_ILL
  } op_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addrsel;
    logic       opa_sel;
    logic       reg_in;
    logic       alu1;
    logic [2:0] alu2;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       reg_write;
    logic       halted;
  } moore_t;

  state_e state_q, state_d;
  moore_t out_q;
  op_e    op;

  // Upper IR bits carry register numbers and immediates consumed by the
  // datapath only; the opcode lives in the low nibble.
  logic unused_ir_hi;
  assign unused_ir_hi = ^bus.ir[7:4];

  // Full low-nibble opcodes take priority over the 3-bit immediate forms.
  function automatic op_e decode_op(input logic [3:0] lo);
    op_e r;
    case (lo)
      4'b0100: r = OP_ADD;
      4'b0110: r = OP_SUB;
      4'b1000: r = OP_NAND;
      4'b0000: r = OP_LOAD;
      4'b0010: r = OP_STORE;
      4'b0101: r = OP_BZ;
      4'b1001: r = OP_BNZ;
      default: begin
        case (lo[2:0])
          3'b011:  r = OP_ADDI;
          3'b111:  r = OP_ORI;
          default: r = OP_ILL;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic moore_t moore_of(input state_e s, input op_e o);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_req = 1'b1;
        m.alu2    = 3'b001;
      end
      S_DECODE: begin
        m.alu2 = 3'b010;                 // ALUout <= PC + Imm4 (branch target)
      end
      S_EXEC_R: begin
        m.alu1   = 1'b1;
        m.alu2   = 3'b000;
        m.alu_op = (o == OP_SUB)  ? 2'b01 :
                   (o == OP_NAND) ? 2'b10 : 2'b00;
      end
      S_EXEC_I: begin
        m.alu1 = 1'b1;
        m.alu2 = 3'b100;
      end
      S_EXEC_ORI: begin
        m.opa_sel = 1'b1;
        m.alu1    = 1'b1;
        m.alu2    = 3'b011;
        m.alu_op  = 2'b11;
      end
      S_WB_ALU: begin
        m.reg_write = 1'b1;
        m.opa_sel   = (o == OP_ORI);     // ORI result always goes to r1
      end
      S_MEM_RD: begin
        m.mem_req = 1'b1;
        m.addrsel = 1'b1;
      end
      S_WB_MEM: begin
        m.reg_write = 1'b1;
        m.reg_in    = 1'b1;
      end
      S_MEM_WR: begin
        m.mem_req = 1'b1;
        m.mem_we  = 1'b1;
        m.addrsel = 1'b1;
      end
      S_BRANCH: m.pc_src = 1'b1;
      S_HALT:   m.halted = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    op = decode_op(bus.ir[3:0]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_NAND: state_d = S_EXEC_R;
          OP_ADDI:                 state_d = S_EXEC_I;
          OP_ORI:                  state_d = S_EXEC_ORI;
          OP_LOAD:                 state_d = S_MEM_RD;
          OP_STORE:                state_d = S_MEM_WR;
          OP_BZ, OP_BNZ:           state_d = S_BRANCH;
          default:                 state_d = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_ORI: state_d = S_WB_ALU;
      S_WB_ALU, S_WB_MEM, S_BRANCH:   state_d = S_FETCH;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;       // unused codes recover to FETCH
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      out_q   <= moore_of(S_FETCH, OP_ILL);
    end else begin
      state_q <= state_d;
      out_q   <= moore_of(state_d, op);
    end
  end

  // Completion strobes: gated by reset so an access abandoned by an
  // asynchronous reset never fires a write.
  logic fetch_done, branch_take;
  assign fetch_done  = !reset && (state_q == S_FETCH) && bus.mem_ready;
  assign branch_take = !reset && (state_q == S_BRANCH) &&
                       ((op == OP_BZ) ? bus.zero : !bus.zero);

  assign bus.ir_write  = fetch_done;
  assign bus.pc_write  = fetch_done || branch_take;
  assign bus.mdr_write = !reset && (state_q == S_MEM_RD) && bus.mem_ready;

  assign bus.mem_req   = out_q.mem_req;
  assign bus.mem_we    = out_q.mem_we;
  assign bus.addrsel   = out_q.addrsel;
  assign bus.opa_sel   = out_q.opa_sel;
  assign bus.reg_in    = out_q.reg_in;
  assign bus.alu1      = out_q.alu1;
  assign bus.alu2      = out_q.alu2;
  assign bus.alu_op    = out_q.alu_op;
  assign bus.pc_src    = out_q.pc_src;
  assign bus.reg_write = out_q.reg_write;
  assign bus.halted    = out_q.halted;
  assign bus.state     = state_q;

endmodule
